// File: rtl/wr_burst_feeder.sv
// Stream-to-burst write feeder: buffers a word stream in a first-word fall-through
// FIFO and issues fixed-length write bursts across a wrapping address region.
module wr_burst_feeder #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned FIFO_DEPTH   = 512,
  parameter int unsigned BURST_LEN    = 16,
  parameter int unsigned BASE_ADDR    = 0,
  parameter int unsigned REGION_BYTES = 32'h0010_0000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH-1:0]       din,
  input  logic                        din_valid,
  output logic                        din_ready,
  input  logic                        frame_sync,
  output logic                        wr_start,
  output logic [ADDR_WIDTH-1:0]       wr_addr,
  output logic [7:0]                  wr_len,
  output logic [DATA_WIDTH-1:0]       wr_data,
  input  logic                        wr_ready,
  input  logic                        wr_done,
  output logic [$clog2(FIFO_DEPTH):0] fill,
  output logic                        busy,
  output logic                        underrun
);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FILL_W = PTR_W + 1;

  localparam logic [PTR_W:0]          L_DEPTH  = FIFO_DEPTH[PTR_W:0];
  localparam logic [PTR_W:0]          L_BLEN_F = BURST_LEN[PTR_W:0];
  localparam logic [8:0]              L_BLEN_B = BURST_LEN[8:0];
  localparam logic [ADDR_WIDTH-1:0]   L_BASE   = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0]   L_BBYTES = ADDR_WIDTH'(BURST_LEN * DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0]   L_END    = ADDR_WIDTH'(BASE_ADDR + REGION_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [DATA_WIDTH-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [PTR_W:0]          r_fill;
  logic [8:0]              r_beat_cnt;
  logic                    r_done_seen;
  logic                    r_sync_pend;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_underrun;

  logic                    w_push;
  logic                    w_pop;
  logic                    w_beat_full;
  logic                    w_burst_end;
  logic [ADDR_WIDTH-1:0]   w_addr_sum;
  logic [ADDR_WIDTH-1:0]   w_addr_inc;

  assign din_ready   = (r_fill != L_DEPTH);
  assign w_push      = din_valid && din_ready;
  assign w_beat_full = (r_beat_cnt == L_BLEN_B);
  assign w_pop       = (r_state == S_DATA) && wr_ready && !w_beat_full && (r_fill != '0);
  assign w_burst_end = (r_state == S_DATA) && w_beat_full && (r_done_seen || wr_done);
  assign w_addr_sum  = r_addr + L_BBYTES;
  assign w_addr_inc  = (w_addr_sum == L_END) ? L_BASE : w_addr_sum;

  // Storage holds no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + FILL_W'(1);
        2'b01:   r_fill <= r_fill - FILL_W'(1);
        default: r_fill <= r_fill;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (r_fill >= L_BLEN_F) w_state_nxt = S_START;
      S_START: w_state_nxt = S_DATA;
      S_DATA:  if (w_burst_end) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A pending rewind is applied only in IDLE, so the address never moves mid-burst
  // and a rewind arriving with the final increment still wins one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat_cnt  <= '0;
      r_done_seen <= 1'b0;
      r_sync_pend <= 1'b0;
      r_addr      <= L_BASE;
      r_underrun  <= 1'b0;
    end else begin
      if (r_state == S_START) begin
        r_beat_cnt  <= '0;
        r_done_seen <= 1'b0;
      end else if (r_state == S_DATA) begin
        if (w_pop)   r_beat_cnt  <= r_beat_cnt + 9'd1;
        if (wr_done) r_done_seen <= 1'b1;
      end
      if (frame_sync)              r_sync_pend <= 1'b1;
      else if (r_state == S_IDLE)  r_sync_pend <= 1'b0;
      if (r_state == S_IDLE && r_sync_pend) r_addr <= L_BASE;
      else if (w_burst_end)                 r_addr <= w_addr_inc;
      if (r_state == S_DATA && wr_ready && (w_beat_full || r_fill == '0))
        r_underrun <= 1'b1;
    end
  end

  assign wr_start = (r_state == S_START);
  assign busy     = (r_state != S_IDLE);
  assign wr_addr  = r_addr;
  assign wr_len   = BURST_LEN[7:0];
  assign wr_data  = r_mem[r_rd_ptr];
  assign fill     = r_fill;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_wr_burst_feeder.sv
// Bench for wr_burst_feeder: drives the stream and emulates the write master,
// comparing against a queue-based model of buffered words and burst addresses.
`timescale 1ns/1ps
module tb_wr_burst_feeder;
  localparam int DW     = 32;
  localparam int AW     = 32;
  localparam int DEPTH  = 512;
  localparam int BL     = 16;
  localparam int BASE   = 0;
  localparam int REGION = 128;
  localparam int BB     = BL * DW / 8;
  localparam int NB     = REGION / BB;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [DW-1:0]            din;
  logic                     din_valid;
  logic                     din_ready;
  logic                     frame_sync;
  logic                     wr_start;
  logic [AW-1:0]            wr_addr;
  logic [7:0]               wr_len;
  logic [DW-1:0]            wr_data;
  logic                     wr_ready;
  logic                     wr_done;
  logic [$clog2(DEPTH):0]   fill;
  logic                     busy;
  logic                     underrun;

  always #5 clk = ~clk;

  wr_burst_feeder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH),
    .BURST_LEN(BL), .BASE_ADDR(BASE), .REGION_BYTES(REGION)
  ) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .frame_sync(frame_sync), .wr_start(wr_start), .wr_addr(wr_addr), .wr_len(wr_len),
    .wr_data(wr_data), .wr_ready(wr_ready), .wr_done(wr_done), .fill(fill),
    .busy(busy), .underrun(underrun)
  );

  int            n_assert = 0;
  int            n_fail   = 0;
  logic [DW-1:0] q[$];
  logic [AW-1:0] addr_log[$];
  int            k        = 0;
  int            beats    = 0;
  int            n_starts = 0;
  int            seq_val  = 1;
  int            overrun_burst = -1;
  int            fs_at[int];
  bit            in_burst     = 1'b0;
  bit            sync_seen    = 1'b0;
  bit            exp_underrun = 1'b0;
  bit            seq_mode     = 1'b0;
  logic [AW-1:0] cur_addr     = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One iteration per cycle, at the falling edge: check, then drive for the next rise.
  task automatic run(input int ncyc, input int push_pct, input int rdy_pct, input int pmax);
    int npush;
    bit was_burst;
    npush = 0;
    for (int c = 0; c < ncyc; c++) begin
      was_burst = in_burst;
      chk("fill", 64'(fill), 64'(q.size()));
      chk("din_ready", 64'(din_ready), 64'(q.size() != DEPTH));
      chk("underrun", 64'(underrun), 64'(exp_underrun));
      chk("busy", 64'(busy), 64'(in_burst || wr_start));
      if (was_burst || q.size() < BL) chk("spurious_start", 64'(wr_start), 64'(0));
      wr_ready = 1'b0; wr_done = 1'b0; frame_sync = 1'b0; din_valid = 1'b0;
      if (in_burst) begin
        chk("wr_addr_hold", 64'(wr_addr), 64'(cur_addr));
        if (beats == BL) begin
          if (fs_at.exists(n_starts) && fs_at[n_starts] == BL) begin
            frame_sync = 1'b1; sync_seen = 1'b1;
          end
          if (overrun_burst == n_starts) begin
            wr_ready = 1'b1; exp_underrun = 1'b1;
          end
          in_burst  = 1'b0;
          k         = sync_seen ? 0 : k + 1;
          sync_seen = 1'b0;
        end else begin
          if (fs_at.exists(n_starts) && fs_at[n_starts] == beats) begin
            frame_sync = 1'b1; sync_seen = 1'b1;
          end
          if (q.size() > 0 && $urandom_range(99) < rdy_pct) begin
            chk("wr_data", 64'(wr_data), 64'(q[0]));
            void'(q.pop_front());
            wr_ready = 1'b1;
            beats++;
            wr_done = (beats == BL);
          end
        end
      end
      if (wr_start && !was_burst) begin
        cur_addr = AW'(BASE + (k % NB) * BB);
        chk("start_addr", 64'(wr_addr), 64'(cur_addr));
        chk("wr_len", 64'(wr_len), 64'(8'(BL)));
        addr_log.push_back(wr_addr);
        n_starts++;
        in_burst = 1'b1;
        beats    = 0;
      end
      if (npush < pmax && $urandom_range(99) < push_pct) begin
        din_valid = 1'b1;
        din = seq_mode ? 32'(seq_val) : $urandom;
        if (din_ready) begin
          q.push_back(din);
          npush++;
          if (seq_mode) seq_val++;
        end
      end
      @(negedge clk);
    end
    din_valid = 1'b0; wr_ready = 1'b0; wr_done = 1'b0; frame_sync = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; din_valid = 1'b0; wr_ready = 1'b0; wr_done = 1'b0; frame_sync = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    in_burst = 1'b0; beats = 0; k = 0; sync_seen = 1'b0; exp_underrun = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0;
    rst = 1'b1; din = '0; din_valid = 1'b0; frame_sync = 1'b0;
    wr_ready = 1'b0; wr_done = 1'b0;
    do_reset();
    chk("rst_fill", 64'(fill), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_wr_start", 64'(wr_start), 64'(0));
    chk("rst_underrun", 64'(underrun), 64'(0));
    chk("rst_din_ready", 64'(din_ready), 64'(1));
    chk("rst_wr_addr", 64'(wr_addr), 64'(BASE));
    chk("rst_wr_len", 64'(wr_len), 64'(16));

    // Words 1..16: nothing until the 16th, then one burst at 0 and address 0x40.
    seq_mode = 1'b1; seq_val = 1;
    run(15, 100, 100, 15);
    chk("no_start_15_words", 64'(n_starts), 64'(0));
    run(1, 100, 100, 1);
    run(2, 0, 100, 0);
    chk("start_within_2", 64'(n_starts), 64'(1));
    run(20, 0, 100, 0);
    chk("b1_addr", 64'(addr_log[0]), 64'(0));
    chk("addr_after_b1", 64'(wr_addr), 64'h40);
    chk("fill_after_b1", 64'(fill), 64'(0));
    chk("idle_after_b1", 64'(busy), 64'(0));

    // Random data and handshake timing, three more bursts across the region wrap.
    seq_mode = 1'b0;
    run(300, 60, 70, 48);
    chk("starts_after_rand", 64'(n_starts), 64'(4));
    chk("wrap_addr1", 64'(addr_log[1]), 64'h40);
    chk("wrap_addr2", 64'(addr_log[2]), 64'h0);
    chk("wrap_addr3", 64'(addr_log[3]), 64'h40);

    // Rewinds: mid-burst at 0, coincident with burst end at 0, mid-burst at 0x40.
    fs_at[5] = 7; fs_at[6] = BL; fs_at[8] = 3;
    run(220, 100, 100, 96);
    chk("starts_after_fs", 64'(n_starts), 64'(10));
    chk("fs_addr5", 64'(addr_log[4]), 64'h0);
    chk("fs_addr6", 64'(addr_log[5]), 64'h0);
    chk("fs_addr7", 64'(addr_log[6]), 64'h0);
    chk("fs_addr8", 64'(addr_log[7]), 64'h40);
    chk("fs_addr9", 64'(addr_log[8]), 64'h0);
    chk("fs_addr10", 64'(addr_log[9]), 64'h40);

    // Fill to capacity with the master stalled, then balanced push and pop.
    run(560, 100, 0, 600);
    chk("full_fill", 64'(fill), 64'(512));
    chk("full_din_ready", 64'(din_ready), 64'(0));
    run(1, 100, 100, 600);
    chk("fill_after_pop", 64'(fill), 64'(511));
    run(8, 100, 100, 600);
    chk("fill_const_push_pop", 64'(fill), 64'(511));
    run(800, 0, 100, 0);
    chk("fill_after_drain", 64'(fill), 64'(8));

    // Extra beat after the last one of a burst raises the sticky error.
    overrun_burst = n_starts + 1;
    run(40, 100, 100, 8);
    chk("underrun_set", 64'(underrun), 64'(1));
    run(5, 0, 0, 0);
    chk("underrun_sticky", 64'(underrun), 64'(1));

    // Reset in the middle of a burst discards the buffered words.
    run(20, 100, 0, 16);
    run(3, 0, 100, 0);
    chk("busy_before_rst", 64'(busy), 64'(1));
    do_reset();
    chk("rst2_fill", 64'(fill), 64'(0));
    chk("rst2_busy", 64'(busy), 64'(0));
    chk("rst2_underrun", 64'(underrun), 64'(0));
    chk("rst2_din_ready", 64'(din_ready), 64'(1));
    chk("rst2_wr_addr", 64'(wr_addr), 64'(BASE));
    s0 = n_starts;
    run(25, 100, 100, 15);
    chk("no_start_after_rst", 64'(n_starts), 64'(s0));
    run(25, 100, 100, 1);
    chk("start_after_rst", 64'(n_starts), 64'(s0 + 1));
    chk("fill_end", 64'(fill), 64'(0));
    chk("addr_end", 64'(wr_addr), 64'h40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
